jtag_master: RTL and testbench
==============================

# jtag_master

Host-side JTAG driver for the on-chip TAP that fronts the ripple-adder boundary-scan chain. It accepts scan commands on a valid/ready interface and generates TCK, TMS and TDI from the system clock. It walks the TAP state machine through IR or DR scans and captures TDO into a response word. It is the initiator end of the same 4-wire link the TAP responds on, and it sits between a test sequencer or CPU and the TAP pins.

## Interface
- MAX_LEN, 64, maximum scan length in bits. Must be at least 51, which is the full boundary chain.
- LEN_W, 7, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset_n  input  1  reset, asynchronous and active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  operation code:
  - 00: DR scan.
  - 01: IR scan.
  - 10: TAP reset.
  - 11: reserved.
- cmd_len  input  LEN_W  number of bits to shift, 1..MAX_LEN.
- cmd_data  input  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  output  1  one-cycle pulse marking command completion.
- rsp_err  output  1  qualifies rsp_valid; set when the command was illegal.
- rsp_data  output  MAX_LEN  captured TDO bits, right-justified.
- TCK  output  1  test clock, idle low.
- TMS  output  1  test mode select.
- TDI  output  1  test data into the TAP.
- TDO  input  1  test data from the TAP; may be high-Z outside shift states.

## Operation
- States: IDLE, RUN, DONE, plus AUTORST when JTAG_MASTER_AUTO_RESET_EN is defined.
- Between commands the TAP is parked in Run-Test/Idle, TCK is held low and TMS is held at 0.
- Accept: a command is taken on the edge where cmd_valid and cmd_ready are both 1. The block latches cmd_op, cmd_len and cmd_data, drops cmd_ready and enters RUN.
- Illegal command: cmd_op=11, cmd_len=0 or cmd_len>MAX_LEN.
  - TCK does not toggle.
  - On the next edge: rsp_valid=1, rsp_err=1, rsp_data unchanged, cmd_ready=1.
- Each TCK bit period lasts 2 CLK cycles. The low phase drives TMS/TDI; the high phase samples TDO.
- TMS sequences:
  - DR scan: 1,0,0, then cmd_len shift bits with TMS=0 except the last shift bit with TMS=1, then 1,0. Total T = len+5 TCKs.
  - IR scan: 1,1,0,0, then the same shift pattern, then 1,0. Total T = len+6.
  - TAP reset: 1,1,1,1,1,0. Total T = 6.
- TDI carries cmd_data[i] during shift bit i and is 0 outside the shift bits.
- TDO is sampled on the TCK rising edge of each shift bit only. The sample taken at shift bit i is stored in rsp_data[i].
- Completion happens in DONE:
  - rsp_valid=1 and rsp_err=0.
  - rsp_data[MAX_LEN-1:cmd_len]=0. TAP reset returns rsp_data=0.
  - cmd_ready=1.
- rsp_data holds until the next rsp_valid pulse.
- cmd_valid while cmd_ready=0 is ignored. The source must hold cmd_valid and its command until accepted.
- Reset_n low:
  - All outputs go to reset values immediately and any scan in progress is abandoned.
  - Without the macro, the TAP state is undefined until the user issues a TAP reset command.

## Timing
- Reset values: TCK=0, TMS=1, TDI=0, rsp_valid=0, rsp_err=0, rsp_data=0.
- Reset value of cmd_ready: 1 without the macro, 0 with it.
- Scan timeline, with acceptance on edge A:
  - Bit k (1-based) drives TMS/TDI and sets TCK=0 at edge A+2k-1.
  - It sets TCK=1 and samples TDO at edge A+2k.
- Completion: at edge A+2T+1, TCK=0, rsp_valid=1 and cmd_ready=1.
  - Earliest next acceptance is A+2T+2.
  - Legal scan latency from acceptance to response is 2T+1 cycles.
- TCK duty cycle is 50%. TMS/TDI change only when TCK falls, giving a full CLK period of setup and hold around each TCK rise.
- TDO is sampled on the same CLK edge that raises TCK, so it captures the value the TAP drove from the previous TCK fall.

## Configuration
- JTAG_MASTER_AUTO_RESET_EN defined:
  - After Reset_n deasserts, the block runs the TAP reset sequence (6 TCKs, 13 cycles) from AUTORST without a command.
  - No rsp_valid pulse is produced for this sequence.
  - cmd_ready rises at the edge that completes it.
- Undefined: cmd_ready=1 on the first edge after reset, and there is no automatic TAP reset.

## Test plan
- TAP reset command → TMS reads 1,1,1,1,1,0 at the 6 TCK rises; rsp_valid with rsp_err=0 and rsp_data=0 at A+13.
- IR scan, len=2, data=2'b10 → TMS reads 1,1,0,0,0,1,1,0; TDI reads 0,1 on the shift bits; rsp_valid at A+17.
- DR scan, len=8, data=0xA5, against a 1-bit bypass model (captures 0 and flops TDI on the TCK fall) → rsp_data=0x4A at A+27.
- cmd_len=0, then a separate command with cmd_op=11 → each gives rsp_valid=1 and rsp_err=1 one cycle after acceptance, with no TCK edge.
- cmd_valid held through a busy scan → second command accepted exactly at A+2T+2; no TCK gap beyond 1 cycle.
- Reset_n pulsed low mid DR scan → TCK=0 and TMS=1 asynchronously; cmd_ready as configured; with the macro, 6 TCKs of TMS pattern 1,1,1,1,1,0 follow release.

Source files
------------

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG scan driver (IR/DR/TAP-reset); define JTAG_MASTER_AUTO_RESET_EN to run a TAP reset after Reset_n releases.
module jtag_master #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               CLK,
  input  logic               Reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);
  localparam int CW = LEN_W + 1;
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);
  localparam logic [1:0] OP_IR = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef JTAG_MASTER_AUTO_RESET_EN
    AUTORST,
`endif
    DONE
  } state_t;
`ifdef JTAG_MASTER_AUTO_RESET_EN
  localparam state_t RST_STATE = AUTORST;
  localparam logic RST_READY = 1'b0;
`else
  localparam state_t RST_STATE = IDLE;
  localparam logic RST_READY = 1'b1;
`endif
  state_t state;
  logic [1:0] op;
  logic [LEN_W-1:0] len;
  logic [MAX_LEN-1:0] data, cap;
  logic [CW-1:0] cnt, pre, last, tot, nk;
  logic [IW-1:0] cur_i, nxt_i;
  logic ill, cur_sh, nxt_sh, nxt_tms;
  // cnt is the 1-based TCK bit currently on the pins; 0 means the scan has not started
  always_comb begin
    pre = (op == OP_IR) ? CW'(4) : CW'(3);
    last = pre + CW'(len);
    tot = (op == OP_RST) ? CW'(6) : last + CW'(2);
    nk = cnt + CW'(1);
    cur_sh = (op != OP_RST) && (cnt > pre) && (cnt <= last);
    nxt_sh = (op != OP_RST) && (nk > pre) && (nk <= last);
    cur_i = IW'(cnt - pre - CW'(1));
    nxt_i = IW'(nk - pre - CW'(1));
    nxt_tms = (op == OP_RST) ? (nk <= CW'(5)) :
              (nk <= pre) ? (nk < pre - CW'(1)) :
              (nk == last || nk == last + CW'(1));
    ill = (op == 2'b11) || (len == '0) || (len > MAXL);
  end
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= RST_STATE;
      op <= OP_RST;
      len <= '0;
      data <= '0;
      cap <= '0;
      cnt <= '0;
      cmd_ready <= RST_READY;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
      TCK <= 1'b0;
      TMS <= 1'b1;
      TDI <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          rsp_err <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            op <= cmd_op;
            len <= cmd_len;
            data <= cmd_data;
            cap <= '0;
            cnt <= '0;
            cmd_ready <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          if (state == RUN && cnt == '0 && ill) begin
            state <= DONE;
            rsp_valid <= 1'b1;
            rsp_err <= 1'b1;
            cmd_ready <= 1'b1;
          end else if (!TCK && cnt != '0) begin
            TCK <= 1'b1;
            if (cur_sh) cap[cur_i] <= TDO;
          end else if (cnt == tot) begin
            TCK <= 1'b0;
            TMS <= 1'b0;
            TDI <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= (state == RUN);
            rsp_err <= 1'b0;
            rsp_data <= cap;
            state <= (state == RUN) ? DONE : IDLE;
          end else begin
            cnt <= nk;
            TCK <= 1'b0;
            TMS <= nxt_tms;
            TDI <= nxt_sh && data[nxt_i];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: scoreboard bench for jtag_master with a list-based model of the TMS/TDI stream and captured TDO.
module tb_jtag_master;
  localparam int ML = 64;
  localparam int LW = 7;
`ifdef JTAG_MASTER_AUTO_RESET_EN
  localparam logic RDY0 = 1'b0;
`else
  localparam logic RDY0 = 1'b1;
`endif
  logic CLK = 1'b0, Reset_n = 1'b1, cmd_valid = 1'b0, TDO = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [ML-1:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_err, TCK, TMS, TDI;
  logic [ML-1:0] rsp_data;
  jtag_master #(.MAX_LEN(ML), .LEN_W(LW)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic err;
    logic [ML-1:0] data;
    int lat;
    int acc;
  } exp_t;
  exp_t sb[$];
  logic [1:0] pin_q[$];
  exp_t px;
  logic [1:0] pe;
  logic pat [0:127];
  int n_cmp = 0, n_bad = 0, cyc = 0, rises = 0, last_acc = 0, a1 = 0;
  logic prev_tck = 1'b0, acc_hit = 1'b0;
  logic [ML-1:0] last_rsp = '0;
  logic [7:0] bp;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    acc_hit <= cmd_valid && cmd_ready;
  end
  task automatic chk(input string nm, input logic [ML-1:0] got, input logic [ML-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask
  // TDO follows a per-command random pattern: bit k of the scan sees pat[k-1]
  always @(negedge CLK) begin
    if (TCK && !prev_tck) begin
      if (pin_q.size() == 0) fail("tck_unexpected_rise");
      else begin
        pe = pin_q.pop_front();
        chk("tms", ML'(TMS), ML'(pe[1]));
        chk("tdi", ML'(TDI), ML'(pe[0]));
      end
      rises++;
    end
    prev_tck = TCK;
    if (acc_hit) rises = 0;
    if (!TCK && rises < 128) TDO = pat[rises];
    if (rsp_valid) begin
      if (sb.size() == 0) fail("rsp_unexpected");
      else begin
        px = sb.pop_front();
        chk("rsp_err", ML'(rsp_err), ML'(px.err));
        chk("rsp_data", rsp_data, px.data);
        chk("latency", ML'(cyc - px.acc), ML'(px.lat));
        chk("tck_at_rsp", ML'(TCK), '0);
        chk("ready_at_rsp", ML'(cmd_ready), ML'(1));
      end
    end
  end
  task automatic new_pat();
    for (int i = 0; i < 128; i++) pat[i] = 1'($urandom);
  endtask
  task automatic push_tap_reset();
    for (int i = 0; i < 6; i++) pin_q.push_back({i < 5, 1'b0});
  endtask
  task automatic send(input logic [1:0] op, input int len, input logic [ML-1:0] data);
    exp_t e;
    int pre, t;
    cmd_op = op;
    cmd_len = LW'(len);
    cmd_data = data;
    cmd_valid = 1'b1;
    for (int i = 0; i < 300 && !cmd_ready; i++) @(negedge CLK);
    if (!cmd_ready) begin
      fail("accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    last_acc = e.acc;
    pre = (op == 2'b01) ? 4 : 3;
    if (op == 2'b11 || len == 0 || len > ML) begin
      e.err = 1'b1;
      e.data = last_rsp;
      e.lat = 1;
    end else begin
      e.err = 1'b0;
      e.data = '0;
      if (op == 2'b10) begin
        push_tap_reset();
        t = 6;
      end else begin
        for (int i = 0; i < pre; i++) pin_q.push_back({i == 0 || (op == 2'b01 && i == 1), 1'b0});
        for (int i = 0; i < len; i++) begin
          pin_q.push_back({i == len - 1, data[i]});
          e.data[i] = pat[pre + i];
        end
        pin_q.push_back(2'b10);
        pin_q.push_back(2'b00);
        t = len + pre + 2;
      end
      e.lat = 2 * t + 1;
      last_rsp = e.data;
    end
    sb.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      fail("rsp_timeout");
      sb.delete();
    end
    @(negedge CLK);
    chk("bits_left", ML'(pin_q.size()), '0);
    pin_q.delete();
  endtask
  task automatic chk_reset_outputs();
    chk("rst_tck", ML'(TCK), '0);
    chk("rst_tms", ML'(TMS), ML'(1));
    chk("rst_tdi", ML'(TDI), '0);
    chk("rst_rsp_valid", ML'(rsp_valid), '0);
    chk("rst_rsp_err", ML'(rsp_err), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_cmd_ready", ML'(cmd_ready), ML'(RDY0));
  endtask
  task automatic release_reset();
    int c0;
`ifdef JTAG_MASTER_AUTO_RESET_EN
    push_tap_reset();
`endif
    c0 = cyc;
    Reset_n = 1'b1;
    last_rsp = '0;
`ifdef JTAG_MASTER_AUTO_RESET_EN
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge CLK);
    chk("autorst_cycles", ML'(cyc - c0), ML'(13));
    chk("autorst_bits_left", ML'(pin_q.size()), '0);
    pin_q.delete();
`else
    @(negedge CLK);
    chk("ready_after_reset", ML'(cmd_ready), ML'(1));
`endif
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    new_pat();
    #1 Reset_n = 1'b0;
    #2 chk_reset_outputs();
    repeat (2) @(negedge CLK);
    release_reset();
    send(2'b10, 8, 64'hFFFF);
    wait_done();
    send(2'b01, 2, 64'h2);
    wait_done();
    bp = 8'hA5;
    for (int i = 0; i < 128; i++) pat[i] = 1'b0;
    for (int i = 1; i < 8; i++) pat[3 + i] = bp[i - 1];
    send(2'b00, 8, 64'hA5);
    wait_done();
    chk("bypass_rsp", rsp_data, 64'h4A);
    send(2'b00, 0, '1);
    wait_done();
    send(2'b11, 5, '1);
    wait_done();
    chk("illegal_keeps_data", rsp_data, 64'h4A);
    new_pat();
    send(2'b00, 64, {$urandom, $urandom});
    wait_done();
    new_pat();
    send(2'b01, 1, {$urandom, $urandom});
    wait_done();
    send(2'b00, 65, {$urandom, $urandom});
    wait_done();
    for (int n = 0; n < 30; n++) begin
      logic [1:0] op;
      int len;
      new_pat();
      op = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 127)))
                                        : int'($urandom_range(1, 64));
      send(op, len, {$urandom, $urandom});
      wait_done();
    end
    new_pat();
    send(2'b00, 10, {$urandom, $urandom});
    a1 = last_acc;
    send(2'b01, 5, {$urandom, $urandom});
    chk("b2b_accept_gap", ML'(last_acc - a1), ML'(32));
    wait_done();
    new_pat();
    send(2'b00, 20, {$urandom, $urandom});
    repeat (15) @(negedge CLK);
    #3 Reset_n = 1'b0;
    #1 chk_reset_outputs();
    sb.delete();
    pin_q.delete();
    @(negedge CLK);
    release_reset();
    new_pat();
    send(2'b00, 6, {$urandom, $urandom});
    wait_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
